acc_sel: RTL and testbench
==========================

# acc_sel

Accept-stage arbiter for the pSLIP crossbar scheduler: the input-side counterpart of the output-side grant selector `pri_sel`. Each scheduling slot, it takes the grant matrix from the grant stage and runs up to `ITER` iSLIP iterations. In each iteration, every unmatched input accepts at most one grant, chosen round-robin from its accept pointer. The accept matrix and the cumulative match masks feed back to the grant stage, which uses them to mask matched ports and update its own pointers.

## Interface
- `N`, default 4: number of ports (inputs = outputs).
- `ITER`, default 2: maximum iSLIP iterations per slot, 1..N.
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle pulse that begins a slot. Honoured only in IDLE.
- `gnt`, in, `[N-1:0][N-1:0]`: `gnt[o][i]` = 1 means output `o` grants input `i`. Sampled every ACC cycle.
- `acc`, out, `[N-1:0][N-1:0]`: `acc[i][o]` = 1 means input `i` accepted output `o` this iteration. Registered; high for one cycle.
- `in_matched`, out, N: cumulative input match mask for the current slot.
- `out_matched`, out, N: cumulative output match mask for the current slot.
- `iter`, out, `$clog2(ITER+1)`: index of the iteration currently being sampled.
- `busy`, out, 1: high in ACC and DONE.
- `done`, out, 1: single-cycle pulse at end of slot.

## Operation
- States and transitions:
  - IDLE → ACC on `start`. On entry, clear `in_matched`, `out_matched` and `iter`.
  - ACC → DONE after the cycle with `iter == ITER-1`, or after any cycle that produces zero new accepts (early convergence).
  - DONE → IDLE unconditionally.
- Each ACC cycle, for each input `i` with `in_matched[i] == 0`:
  - Candidates: `cand[o] = gnt[o][i] & ~out_matched[o]`.
  - Choose the first set `o` at or after `a_ptr[i]`, scanning circularly (indices wrap N-1 → 0).
  - If a candidate exists: set `acc[i][o]` and set `in_matched[i]` and `out_matched[o]` on the same edge.
- Pointer update: only for accepts made in iteration 0, `a_ptr[i] <= (o+1) mod N`. Accepts made in later iterations leave pointers unchanged (iSLIP starvation-freedom rule).
- Input contract: the grant stage presents at most one set bit per row `gnt[o][*]`. The block does not repair violations; the bench asserts the contract.
- `in_matched` and `out_matched` hold their values through DONE and IDLE until the next accepted `start`.
- `start` while `busy` is ignored.
- `reset`, including mid-slot: state → IDLE; `acc`, masks, `iter`, `busy`, `done` and all `a_ptr` → 0.

## Timing
- Reset value of every output is 0.
- ACC cycle k samples `gnt` and drives `iter == k`. The corresponding `acc` pulse and mask update are visible in cycle k+1. The grant stage must present its iteration-k grants during cycle k.
- First ACC cycle is the cycle after `start`.
- `done` is high in the cycle after the last ACC cycle, coincident with the final `acc` pulse.
- Slot length: 1 + ITER + 1 cycles worst case; 3 cycles minimum.
- Earliest next `start` is the cycle after DONE. Back-to-back slots: `start` on that IDLE cycle.

## Structure
- Package `pslip_pkg` holds:
  - `PTR_W = $clog2(N)`.
  - Typedef `req_mat_t` for the NxN matrix.
  - FSM enum `acc_state_e {IDLE, ACC, DONE}`.
- Sub-module `rr_pick`: combinational N-bit circular priority picker, taking `req` and `ptr` and returning `idx` and `valid`. Instantiate one per input via generate. `pri_sel` shares this picker.
- Top level holds the FSM, iteration counter, pointer registers and match masks. Target size about 200 lines.

## Test plan
All cases use N=4, ITER=2.
- **Reset:** hold `reset` 3 cycles mid-ACC. Required: all outputs 0, state IDLE, and the next slot picks from pointer 0.
- **Pointer advance:** `start`, then in iter0 drive `gnt[o][0]=1` for all `o`. Required: `acc[0][0]`, `in_matched=0001`, `out_matched=0001`, `done` at cycle 3. Repeat the slot. Required: `acc[0][1]` (pointer advanced to 1).
- **Second iteration:**
  - iter0: `gnt[0][0]=1`, `gnt[1][1]=0`. Required: `acc[0][0]`.
  - iter1: `gnt[1][1]=1`. Required: `acc[1][1]`, `out_matched=0011`, `a_ptr[1]` remains 0 (check via next slot: `gnt[1][1]`, `gnt[0][1]` → accepts o0).
- **Early convergence:** `start` with `gnt=0`. Required: one ACC cycle, `done` 2 cycles after `start`, masks 0.
- **Wrap and masking:** preset `a_ptr[2]=3` via prior slots, then grant from o0 and o3 to input 2. Required: `acc[2][3]`, pointer → 0. Separately, grants to an already-matched output are never accepted.
- **Busy protection:** assert `start` during ACC. Required: ignored, with no mask clear and no extra `done`.

Source files
------------

// File: rtl/pslip_pkg.sv
// Shared types and default sizing for the pSLIP crossbar scheduler stages.
package pslip_pkg;

    localparam int unsigned NPORT = 4;
    localparam int unsigned NITER = 2;
    localparam int unsigned PTR_W = $clog2(NPORT);

    // Port-by-port request/grant/accept matrix at the default size
    typedef logic [NPORT-1:0][NPORT-1:0] req_mat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set request at or after ptr.
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         valid
);

    int unsigned sum;
    logic [W-1:0] pos;

    // Walk offsets 0..N-1 from ptr; the first hit wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = 0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = 32'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            pos = W'(sum);
            if (req[pos] && !valid) begin
                idx   = pos;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_sel.sv
// iSLIP accept stage: per-slot multi-iteration accept with round-robin pointers.
module acc_sel
    import pslip_pkg::*;
#(
    parameter int unsigned N    = NPORT,
    parameter int unsigned ITER = NITER,
    parameter int unsigned IW   = $clog2(ITER + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N-1:0][N-1:0] gnt,
    output logic [N-1:0][N-1:0] acc,
    output logic [N-1:0]        in_matched,
    output logic [N-1:0]        out_matched,
    output logic [IW-1:0]       iter,
    output logic                busy,
    output logic                done
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    acc_state_e state;
    acc_state_e state_nx;

    logic [PW-1:0]       a_ptr     [N];
    logic [PW-1:0]       a_ptr_d   [N];
    logic [PW-1:0]       pick_idx  [N];
    logic [N-1:0]        pick_vld;
    logic [N-1:0][N-1:0] cand;

    logic [N-1:0][N-1:0] acc_c;
    logic [N-1:0]        new_in_c;
    logic [N-1:0]        new_out_c;
    logic                any_new_c;
    logic                last_iter_c;

    logic [N-1:0][N-1:0] acc_d;
    logic [N-1:0]        in_matched_d;
    logic [N-1:0]        out_matched_d;
    logic [IW-1:0]       iter_d;
    logic                busy_d;
    logic                done_d;

    // Per-input candidate vector: outputs granting this input and not yet taken
    always_comb begin
        cand = '0;
        for (int i = 0; i < N; i++) begin
            for (int o = 0; o < N; o++) begin
                cand[i][o] = gnt[o][i] & ~out_matched[o];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_pick
        rr_pick #(
            .N (N),
            .W (PW)
        ) u_pick (
            .req   (cand[gi]),
            .ptr   (a_ptr[gi]),
            .idx   (pick_idx[gi]),
            .valid (pick_vld[gi])
        );
    end

    // Accepts this cycle; each output grants at most one input, so no collisions
    always_comb begin
        acc_c     = '0;
        new_in_c  = '0;
        new_out_c = '0;
        for (int i = 0; i < N; i++) begin
            if ((state == ACC) && !in_matched[i] && pick_vld[i]) begin
                acc_c[i][pick_idx[i]] = 1'b1;
                new_in_c[i]           = 1'b1;
                new_out_c[pick_idx[i]] = 1'b1;
            end
        end
    end

    assign any_new_c   = |new_in_c;
    assign last_iter_c = (iter == IW'(ITER - 1));

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            in_matched  <= '0;
            out_matched <= '0;
            iter        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_ptr[i] <= '0;
            end
        end else begin
            state       <= state_nx;
            acc         <= acc_d;
            in_matched  <= in_matched_d;
            out_matched <= out_matched_d;
            iter        <= iter_d;
            busy        <= busy_d;
            done        <= done_d;
            for (int i = 0; i < N; i++) begin
                a_ptr[i] <= a_ptr_d[i];
            end
        end
    end

    // Next-state logic; a slot ends on the last iteration or when nothing new matched
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ACC;
                end
            end
            ACC: begin
                if (last_iter_c || !any_new_c) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values for registered outputs, masks, iteration counter and pointers
    always_comb begin
        acc_d         = acc_c;
        in_matched_d  = in_matched;
        out_matched_d = out_matched;
        iter_d        = iter;
        busy_d        = (state_nx != IDLE);
        done_d        = (state_nx == DONE);
        for (int i = 0; i < N; i++) begin
            a_ptr_d[i] = a_ptr[i];
        end

        if ((state == IDLE) && start) begin
            in_matched_d  = '0;
            out_matched_d = '0;
            iter_d        = '0;
        end

        if (state == ACC) begin
            in_matched_d  = in_matched | new_in_c;
            out_matched_d = out_matched | new_out_c;
            if (state_nx == ACC) begin
                iter_d = iter + IW'(1);
            end
            // Only first-iteration accepts move pointers, keeping iSLIP starvation-free
            if (iter == '0) begin
                for (int i = 0; i < N; i++) begin
                    if (new_in_c[i]) begin
                        a_ptr_d[i] = (pick_idx[i] == PW'(N - 1)) ? '0 : pick_idx[i] + PW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_sel.sv
// Scoreboard bench for acc_sel: slot-level reference model feeds a queue drained by a monitor.
module tb_acc_sel;
    import pslip_pkg::*;

    localparam int N    = 4;
    localparam int ITER = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    req_mat_t   gnt;
    req_mat_t   acc;
    logic [N-1:0] in_matched;
    logic [N-1:0] out_matched;
    logic [1:0] iter;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    acc_sel #(
        .N    (N),
        .ITER (ITER)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .gnt         (gnt),
        .acc         (acc),
        .in_matched  (in_matched),
        .out_matched (out_matched),
        .iter        (iter),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        req_mat_t     acc;
        logic [N-1:0] im;
        logic [N-1:0] om;
        logic         done;
    } exp_t;

    exp_t     sbq[$];
    exp_t     e_mon;
    int       checks = 0;
    int       errors = 0;
    int       aptr[N];
    req_mat_t acc_seen;
    bit       mon_en    = 1'b0;
    bit       prev_busy = 1'b0;
    bit       prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic req_mat_t bit2(input int a, input int b);
        req_mat_t m;
        m       = '0;
        m[a][b] = 1'b1;
        return m;
    endfunction

    function automatic req_mat_t rnd_gnt();
        req_mat_t m;
        m = '0;
        for (int o = 0; o < N; o++) begin
            if ($urandom_range(0, 2) != 0) begin
                m[o][$urandom_range(0, N - 1)] = 1'b1;
            end
        end
        return m;
    endfunction

    // Reference: iterate the accept rule over a whole slot, queue one result per ACC cycle
    task automatic model_slot(input req_mat_t gl[ITER], output int n_acc);
        logic [N-1:0] im, om, om0;
        req_mat_t     a;
        int           nnew;
        int           o;
        exp_t         e;
        im    = '0;
        om    = '0;
        n_acc = 0;
        for (int k = 0; k < ITER; k++) begin
            a    = '0;
            nnew = 0;
            om0  = om;
            for (int i = 0; i < N; i++) begin
                if (!im[i]) begin
                    for (int s = 0; s < N; s++) begin
                        o = (aptr[i] + s) % N;
                        if (gl[k][o][i] && !om0[o]) begin
                            a[i][o] = 1'b1;
                            im[i]   = 1'b1;
                            om[o]   = 1'b1;
                            nnew++;
                            if (k == 0) aptr[i] = (o + 1) % N;
                            break;
                        end
                    end
                end
            end
            n_acc  = k + 1;
            e.acc  = a;
            e.im   = im;
            e.om   = om;
            e.done = (k == ITER - 1) || (nnew == 0);
            sbq.push_back(e);
            if (e.done) break;
        end
    endtask

    // Drive one slot from an IDLE negedge; returns at the following IDLE negedge
    task automatic run_slot(input string nm, input req_mat_t g0, input req_mat_t g1,
                            input bit prot, input bit directed, input req_mat_t xa,
                            input logic [N-1:0] xi, input logic [N-1:0] xo, input int xc);
        req_mat_t gl[ITER];
        int n_acc;
        int done_k;
        gl[0] = g0;
        gl[1] = g1;
        for (int k = 0; k < ITER; k++) begin
            for (int o = 0; o < N; o++) begin
                assert ($onehot0(gl[k][o])) else $error("grant row contract broken");
            end
        end
        chk({nm, "_idle_before_start"}, 64'(busy), 64'(0));
        model_slot(gl, n_acc);
        acc_seen = '0;
        start    = 1'b1;
        gnt      = '0;
        done_k   = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin
                done_k = k;
                start  = 1'b0;
                gnt    = '0;
                break;
            end
            start = prot && (k < n_acc);
            gnt   = '0;
            if (k < n_acc) begin
                gnt = gl[k];
                chk({nm, "_iter"}, 64'(iter), 64'(k));
                chk({nm, "_busy"}, 64'(busy), 64'(1));
            end
        end
        chk({nm, "_slot_cycles"}, 64'(done_k + 1), 64'(n_acc + 1));
        if (done_k < 0) begin
            // Time out: stop here with a report rather than hang
            $display("FAIL %s_done_timeout got none want pulse", nm);
            errors++;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "done never seen");
        end
        @(negedge clk);
        if (directed) begin
            chk({nm, "_cycles_spec"}, 64'(done_k + 1), 64'(xc));
            chk({nm, "_acc_spec"}, 64'(acc_seen), 64'(xa));
            chk({nm, "_in_matched_hold"}, 64'(in_matched), 64'(xi));
            chk({nm, "_out_matched_hold"}, 64'(out_matched), 64'(xo));
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_acc"}, 64'(acc), 64'(0));
        chk({nm, "_in_matched"}, 64'(in_matched), 64'(0));
        chk({nm, "_out_matched"}, 64'(out_matched), 64'(0));
        chk({nm, "_iter"}, 64'(iter), 64'(0));
        chk({nm, "_busy"}, 64'(busy), 64'(0));
        chk({nm, "_done"}, 64'(done), 64'(0));
    endtask

    // Monitor: each cycle following an ACC cycle carries one result
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_busy && !prev_done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got acc %0h want none", acc);
                end else begin
                    e_mon = sbq.pop_front();
                    chk("sb_acc", 64'(acc), 64'(e_mon.acc));
                    chk("sb_in_matched", 64'(in_matched), 64'(e_mon.im));
                    chk("sb_out_matched", 64'(out_matched), 64'(e_mon.om));
                    chk("sb_done", 64'(done), 64'(e_mon.done));
                    acc_seen = acc_seen | acc;
                end
            end else begin
                chk("no_stray_done", 64'(done), 64'(0));
            end
        end
        prev_busy = busy;
        prev_done = done;
    end

    req_mat_t all0;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        gnt   = '0;
        for (int i = 0; i < N; i++) aptr[i] = 0;
        all0 = bit2(0, 0) | bit2(1, 0) | bit2(2, 0) | bit2(3, 0);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        run_slot("ptr_adv", all0, all0, 0, 1, bit2(0, 0), 4'b0001, 4'b0001, 3);
        run_slot("ptr_adv2", all0, all0, 0, 1, bit2(0, 1), 4'b0001, 4'b0010, 3);
        run_slot("iter2", bit2(0, 0), bit2(1, 1), 0, 1,
                 bit2(0, 0) | bit2(1, 1), 4'b0011, 4'b0011, 3);
        run_slot("iter2_ptr", bit2(1, 1) | bit2(0, 1), '0, 0, 1,
                 bit2(1, 0), 4'b0010, 4'b0001, 3);
        run_slot("early", '0, '0, 0, 1, '0, 4'b0000, 4'b0000, 2);
        run_slot("wrap_pre", bit2(2, 2), '0, 0, 1, bit2(2, 2), 4'b0100, 4'b0100, 3);
        run_slot("wrap", bit2(0, 2) | bit2(3, 2), '0, 0, 1,
                 bit2(2, 3), 4'b0100, 4'b1000, 3);
        run_slot("wrap_ptr0", bit2(0, 2) | bit2(3, 2), '0, 0, 1,
                 bit2(2, 0), 4'b0100, 4'b0001, 3);
        run_slot("mask", bit2(0, 0), bit2(0, 1), 0, 1, bit2(0, 0), 4'b0001, 4'b0001, 3);
        run_slot("busy_prot", bit2(1, 3), bit2(2, 0), 1, 1,
                 bit2(3, 1) | bit2(0, 2), 4'b1001, 4'b0110, 3);

        for (int t = 0; t < 30; t++) begin
            run_slot("rnd", rnd_gnt(), rnd_gnt(), 1'($urandom_range(0, 1)), 0, '0, '0, '0, 0);
        end

        // Reset in the middle of a slot, after an iteration-0 accept
        mon_en = 1'b0;
        sbq.delete();
        start  = 1'b1;
        gnt    = '0;
        @(negedge clk);
        start = 1'b0;
        gnt   = bit2(1, 2);
        @(negedge clk);
        chk("mid_reset_in_acc", 64'(busy), 64'(1));
        reset = 1'b1;
        gnt   = '0;
        repeat (3) @(negedge clk);
        chk_zero("mid_reset");
        reset = 1'b0;
        for (int i = 0; i < N; i++) aptr[i] = 0;
        @(negedge clk);
        chk_zero("post_reset");
        mon_en = 1'b1;
        run_slot("post_reset_ptr0", all0, '0, 0, 1, bit2(0, 0), 4'b0001, 4'b0001, 3);

        for (int t = 0; t < 20; t++) begin
            run_slot("rnd2", rnd_gnt(), rnd_gnt(), 1'($urandom_range(0, 1)), 0, '0, '0, '0, 0);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(sbq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
